// File: rtl/pipe_scoreboard.sv
// -----------------------------------------------------------------------------
// pipe_scoreboard
//
// Register scoreboard that sits beside the decode (ID) stage. It tracks
// registers that have a write pending. For each register it keeps a
// cycles-remaining counter for fixed-latency producers (ALU, load, multi-cycle
// multiply) and a flag for unbounded producers (divider). An unbounded
// producer is released by an explicit writeback. From this state and the
// instruction in ID, the block decides between stall and issue. It also keeps
// a saturating count of stall cycles.
//
// Parameters
//   NREG      number of architectural registers
//   AW        register index width
//   LW        latency field width; finite latencies 1..2^LW-1, 0 = unbounded
//   SCW       stall counter width
//   HARD_ZERO when non-zero, register 0 is never tracked and never stalls
//
// Ports
//   i_clock        rising-edge clock
//   i_resetn       synchronous active-low reset
//   i_id_valid     ID holds a valid instruction
//   i_id_rs/rt     source register indices
//   i_id_use_rs/rt instruction reads rs / rt
//   i_id_wreg      instruction writes a register
//   i_id_rn        destination register index
//   i_id_lat       producer latency in cycles, 0 = unbounded
//   i_flush        ID instruction is squashed this cycle
//   i_wb_valid     an unbounded producer completes
//   i_wb_rn        register completed by the unbounded producer
//   o_stall        hold PC and IF/ID
//   o_issue        ID instruction advances this cycle
//   o_pend_mask    bit i set while register i is pending
//   o_stall_count  saturating count of stall cycles
// -----------------------------------------------------------------------------
module pipe_scoreboard #(
   parameter int NREG      = 32,
   parameter int AW        = 5,
   parameter int LW        = 3,
   parameter int SCW       = 16,
   parameter int HARD_ZERO = 1
) (
   input  logic            i_clock,
   input  logic            i_resetn,
   input  logic            i_id_valid,
   input  logic [AW-1:0]   i_id_rs,
   input  logic [AW-1:0]   i_id_rt,
   input  logic            i_id_use_rs,
   input  logic            i_id_use_rt,
   input  logic            i_id_wreg,
   input  logic [AW-1:0]   i_id_rn,
   input  logic [LW-1:0]   i_id_lat,
   input  logic            i_flush,
   input  logic            i_wb_valid,
   input  logic [AW-1:0]   i_wb_rn,
   output logic            o_stall,
   output logic            o_issue,
   output logic [NREG-1:0] o_pend_mask,
   output logic [SCW-1:0]  o_stall_count
);

   localparam logic [LW-1:0]  L_CNT_ZERO = {LW{1'b0}};
   localparam logic [LW-1:0]  L_CNT_ONE  = {{(LW-1){1'b0}}, 1'b1};
   localparam logic [SCW-1:0] L_SC_MAX   = {SCW{1'b1}};
   localparam logic [SCW-1:0] L_SC_ONE   = {{(SCW-1){1'b0}}, 1'b1};

   // Register 0 drops out of every hazard check and scoreboard load when it
   // is hardwired.
   function automatic logic f_tracked(input logic [AW-1:0] idx);
      logic tracked;
      if ((HARD_ZERO != 32'sd0) && (idx == {AW{1'b0}})) begin
         tracked = 1'b0;
      end else begin
         tracked = 1'b1;
      end
      return tracked;
   endfunction

   // A source still needs the result when the value cannot be forwarded yet.
   // cnt==1 means the result is on the bypass this cycle, so it does not count.
   function automatic logic f_src_busy(input logic [LW-1:0] cnt, input logic unb);
      return unb | (cnt > L_CNT_ONE);
   endfunction

   // Registered scoreboard state
   logic [LW-1:0]   r_cnt [NREG];
   logic [NREG-1:0] r_unb;
   logic [NREG-1:0] r_pend_mask;
   logic [SCW-1:0]  r_stall_count;

   // Decode and next-state wires
   logic            w_lat_unb;
   logic            w_raw_a;
   logic            w_raw_b;
   logic            w_waw;
   logic            w_hazard;
   logic            w_stall;
   logic            w_issue;
   logic            w_load;
   logic [LW-1:0]   w_cnt_rs;
   logic [LW-1:0]   w_cnt_rt;
   logic [LW-1:0]   w_cnt_rn;
   logic [LW-1:0]   w_cnt_nxt [NREG];
   logic [NREG-1:0] w_unb_nxt;
   logic [NREG-1:0] w_pend_nxt;

   assign w_lat_unb = (i_id_lat == L_CNT_ZERO);
   assign w_cnt_rs  = r_cnt[i_id_rs];
   assign w_cnt_rt  = r_cnt[i_id_rt];
   assign w_cnt_rn  = r_cnt[i_id_rn];

   // Hazard decode for the instruction in ID, from registered state only
   always_comb begin
      w_raw_a = i_id_use_rs & f_tracked(i_id_rs) & f_src_busy(w_cnt_rs, r_unb[i_id_rs]);
      w_raw_b = i_id_use_rt & f_tracked(i_id_rt) & f_src_busy(w_cnt_rt, r_unb[i_id_rt]);
      // A new writer must not complete before an older writer of the same
      // register. An unbounded newcomer may only follow a writer that is
      // already on the bypass.
      if (i_id_wreg && f_tracked(i_id_rn)) begin
         if (r_unb[i_id_rn]) begin
            w_waw = 1'b1;
         end else if (w_lat_unb) begin
            w_waw = (w_cnt_rn > L_CNT_ONE);
         end else begin
            w_waw = (w_cnt_rn > i_id_lat);
         end
      end else begin
         w_waw = 1'b0;
      end
      w_hazard = w_raw_a | w_raw_b | w_waw;
   end

   // Stall/issue decision; a squashed, absent or in-reset instruction does neither
   always_comb begin
      w_stall = 1'b0;
      w_issue = 1'b0;
      if (i_resetn && i_id_valid && !i_flush) begin
         w_stall = w_hazard;
         w_issue = ~w_hazard;
      end else begin
         w_stall = 1'b0;
         w_issue = 1'b0;
      end
      w_load = w_issue & i_id_wreg & f_tracked(i_id_rn);
   end

   assign o_stall = w_stall;
   assign o_issue = w_issue;

   // Per-register next state: an issuing load overrides both the countdown
   // and a same-cycle writeback to that register
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_unb_nxt = r_unb;
      for (int i = 0; i < NREG; i++) begin
         if (w_load && (i_id_rn == AW'(i))) begin
            if (w_lat_unb) begin
               w_cnt_nxt[i] = L_CNT_ZERO;
               w_unb_nxt[i] = 1'b1;
            end else begin
               w_cnt_nxt[i] = i_id_lat;
               w_unb_nxt[i] = 1'b0;
            end
         end else begin
            if (r_cnt[i] != L_CNT_ZERO) begin
               w_cnt_nxt[i] = r_cnt[i] - L_CNT_ONE;
            end else begin
               w_cnt_nxt[i] = L_CNT_ZERO;
            end
            // A writeback to a register without an unbounded producer clears
            // an already-clear flag, so it has no effect.
            if (i_wb_valid && (i_wb_rn == AW'(i))) begin
               w_unb_nxt[i] = 1'b0;
            end else begin
               w_unb_nxt[i] = r_unb[i];
            end
         end
      end
   end

   // Pending mask derived from next state so that the output is a flop
   always_comb begin
      w_pend_nxt = {NREG{1'b0}};
      for (int i = 0; i < NREG; i++) begin
         w_pend_nxt[i] = (w_cnt_nxt[i] != L_CNT_ZERO) | w_unb_nxt[i];
      end
      if (HARD_ZERO != 32'sd0) begin
         w_pend_nxt[0] = 1'b0;
      end else begin
         w_pend_nxt[0] = (w_cnt_nxt[0] != L_CNT_ZERO) | w_unb_nxt[0];
      end
   end

   // Scoreboard state and pending-mask registers
   always_ff @(posedge i_clock) begin
      if (!i_resetn) begin
         for (int i = 0; i < NREG; i++) begin
            r_cnt[i] <= L_CNT_ZERO;
         end
         r_unb       <= {NREG{1'b0}};
         r_pend_mask <= {NREG{1'b0}};
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_unb       <= w_unb_nxt;
         r_pend_mask <= w_pend_nxt;
      end
   end

   // Saturating stall-cycle counter
   always_ff @(posedge i_clock) begin
      if (!i_resetn) begin
         r_stall_count <= {SCW{1'b0}};
      end else if (w_stall && (r_stall_count != L_SC_MAX)) begin
         r_stall_count <= r_stall_count + L_SC_ONE;
      end else begin
         r_stall_count <= r_stall_count;
      end
   end

   assign o_pend_mask   = r_pend_mask;
   assign o_stall_count = r_stall_count;

endmodule
